requant_out_x16: RTL and testbench

- Post-processing stage directly downstream of the 16-lane calc unit.
- Takes 16 signed 32-bit accumulator results per valid beat and applies per-lane bias add, a fixed-point multiply/shift requantize, zero-point offset, optional ReLU and int8 saturation.
- Packs the 16 int8 results into one 128-bit word and buffers it in a small FIFO with valid/ready toward the feature-map write-back logic.
- Raises an almost-full flag so the scheduler can stall the calc array, which has no backpressure input.

---
 rtl/requant_out_x16.sv | 191 +++++++++++++++++++
 tb/tb_requant_out_x16.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/requant_out_x16.sv
// requant_out_x16
//   Post-processing stage behind the 16-lane calc unit. Each valid beat carries
//   16 signed 32-bit accumulators. Each lane goes through these steps:
//   saturating bias add, exact multiply by q_mult, round-half-up right shift,
//   zero-point add, optional ReLU, and int8 clamp. The 16 int8 results are
//   packed into one 128-bit word and queued in a first-word-fall-through FIFO.
//
// Ports
//   clk_100M, rst           : clock, synchronous active-high reset
//   data_in_vld             : accumulator beat valid (no ready; upstream stalls on fifo_afull)
//   data_in, bias_in        : 16 x signed 32-bit, lane i at [i*32 +: 32]
//   q_mult/q_shift/q_zp     : requant multiplier, right shift, output zero point
//   relu_en                 : low clamp bound becomes q_zp instead of -128
//   frame_len               : beats per frame (0 means 65536)
//   new_start               : clears the frame beat counter and ovf_flag
//   dout_vld/dout_rdy/dout  : FIFO head handshake, 16 x int8, lane i at [i*8 +: 8]
//   dout_last               : head beat closes a frame
//   fifo_afull              : occupancy >= FIFO_DEPTH - AFULL_TH
//   ovf_flag                : sticky, a beat was dropped on a full FIFO
module requant_out_x16 #(
  parameter int FIFO_DEPTH = 8,
  parameter int AFULL_TH   = 4
) (
  input  logic         clk_100M,
  input  logic         rst,
  input  logic         data_in_vld,
  input  logic [511:0] data_in,
  input  logic [511:0] bias_in,
  input  logic [15:0]  q_mult,
  input  logic [4:0]   q_shift,
  input  logic [7:0]   q_zp,
  input  logic         relu_en,
  input  logic [15:0]  frame_len,
  input  logic         new_start,
  output logic         dout_vld,
  input  logic         dout_rdy,
  output logic [127:0] dout,
  output logic         dout_last,
  output logic         fifo_afull,
  output logic         ovf_flag
);

  localparam int LANES = 16;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  // Per-beat parameters travel with the data so that later changes on the
  // inputs never touch a beat that is already in the pipeline.
  typedef struct packed {
    logic [4:0]        shift;
    logic signed [7:0] zp;
    logic              relu;
  } qpost_t;

  typedef struct packed {
    logic [15:0] mult;
    qpost_t      post;
  } qparam_t;

  function automatic logic [7:0] requant_lane(input logic signed [48:0] prod,
                                              input logic [4:0]         shift,
                                              input logic signed [7:0]  zp,
                                              input logic               relu);
    logic signed [49:0] rnd;
    logic signed [49:0] rounded;
    logic signed [49:0] shifted;
    logic signed [49:0] biased;
    logic signed [49:0] lo;
    // Adding half an LSB before the arithmetic shift rounds half up toward +inf.
    rnd     = (shift == 5'd0) ? 50'sd0 : (50'sd1 <<< (shift - 5'd1));
    rounded = 50'(prod) + rnd;
    shifted = rounded >>> shift;
    biased  = shifted + 50'(zp);
    lo      = relu ? 50'(zp) : -50'sd128;
    if (biased > 50'sd127)  return 8'h7F;
    else if (biased < lo)   return lo[7:0];
    else                    return biased[7:0];
  endfunction

  // ---------------- pipeline ----------------
  logic                s1_vld, s2_vld, s3_vld;
  qparam_t             s1_q;
  qpost_t              s2_post;
  logic signed [31:0]  s1_sum  [LANES];
  logic signed [48:0]  s2_prod [LANES];
  logic [127:0]        s3_res;

  logic signed [32:0]  sum_wide [LANES];
  logic signed [31:0]  sum_sat  [LANES];
  logic [127:0]        lane_res;

  // NOTE: every always_comb output gets a default before any branch; otherwise
  // a path that skips the assignment would infer a latch.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      sum_wide[i] = '0;
      sum_sat[i]  = '0;
    end
    for (int i = 0; i < LANES; i++) begin
      sum_wide[i] = {data_in[i*32+31], data_in[i*32 +: 32]} +
                    {bias_in[i*32+31], bias_in[i*32 +: 32]};
      // Bits 32 and 31 disagree only when the 33-bit sum left the int32 range.
      if (sum_wide[i][32] != sum_wide[i][31])
        sum_sat[i] = sum_wide[i][32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
      else
        sum_sat[i] = sum_wide[i][31:0];
    end
  end

  always_comb begin
    lane_res = '0;
    for (int i = 0; i < LANES; i++)
      lane_res[i*8 +: 8] = requant_lane(s2_prod[i], s2_post.shift, s2_post.zp, s2_post.relu);
  end

  // ---------------- frame counter / FIFO control ----------------
  logic [128:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          pop, push_ok, drop, fifo_full;
  logic [15:0]   beat_cnt, cnt_base;
  logic          wr_last;

  assign fifo_full = (count == CW'(FIFO_DEPTH));
  assign dout_vld  = (count != '0);
  assign pop       = dout_vld & dout_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok   = s3_vld & (~fifo_full | pop);
  assign drop      = s3_vld & fifo_full & ~pop;

  // A new_start coinciding with a write makes that write beat 0.
  // frame_len = 0 gives 16'hFFFF here, i.e. a 65536-beat frame.
  assign cnt_base  = new_start ? 16'd0 : beat_cnt;
  assign wr_last   = (cnt_base == frame_len - 16'd1);

  always_comb begin
    count_next = count;
    case ({push_ok, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  assign {dout_last, dout} = dout_vld ? mem[rd_ptr] : 129'd0;

  // Control state: valids, pointers, counters, flags.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      s1_vld     <= 1'b0;
      s2_vld     <= 1'b0;
      s3_vld     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      beat_cnt   <= '0;
      fifo_afull <= 1'b0;
      ovf_flag   <= 1'b0;
    end else begin
      s1_vld     <= data_in_vld;
      s2_vld     <= s1_vld;
      s3_vld     <= s2_vld;
      count      <= count_next;
      fifo_afull <= (count_next >= CW'(FIFO_DEPTH - AFULL_TH));
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok) beat_cnt <= wr_last ? 16'd0 : cnt_base + 16'd1;
      else         beat_cnt <= cnt_base;
      if (new_start) ovf_flag <= 1'b0;
      else if (drop) ovf_flag <= 1'b1;
    end
  end

  // NOTE: data registers and FIFO storage are not reset; they are only ever
  // observed behind a valid that is reset, and all state uses non-blocking
  // assignments so every stage samples the previous stage's old value.
  always_ff @(posedge clk_100M) begin
    if (data_in_vld) begin
      s1_q <= '{mult: q_mult, post: '{shift: q_shift, zp: q_zp, relu: relu_en}};
      for (int i = 0; i < LANES; i++) s1_sum[i] <= sum_sat[i];
    end
    if (s1_vld) begin
      s2_post <= s1_q.post;
      for (int i = 0; i < LANES; i++)
        s2_prod[i] <= 49'(s1_sum[i]) * 49'($signed({1'b0, s1_q.mult}));
    end
    if (s2_vld)  s3_res <= lane_res;
    if (push_ok) mem[wr_ptr] <= {wr_last, s3_res};
  end

endmodule

// File: tb/tb_requant_out_x16.sv
module tb_requant_out_x16;

  logic         clk_100M = 1'b0;
  logic         rst = 1'b1;
  logic         data_in_vld = 1'b0;
  logic [511:0] data_in = '0;
  logic [511:0] bias_in = '0;
  logic [15:0]  q_mult = '0;
  logic [4:0]   q_shift = '0;
  logic [7:0]   q_zp = '0;
  logic         relu_en = 1'b0;
  logic [15:0]  frame_len = '0;
  logic         new_start = 1'b0;
  logic         dout_vld;
  logic         dout_rdy = 1'b0;
  logic [127:0] dout;
  logic         dout_last;
  logic         fifo_afull;
  logic         ovf_flag;

  always #5 clk_100M = ~clk_100M;

  requant_out_x16 #(.FIFO_DEPTH(8), .AFULL_TH(4)) dut (
    .clk_100M   (clk_100M),
    .rst        (rst),
    .data_in_vld(data_in_vld),
    .data_in    (data_in),
    .bias_in    (bias_in),
    .q_mult     (q_mult),
    .q_shift    (q_shift),
    .q_zp       (q_zp),
    .relu_en    (relu_en),
    .frame_len  (frame_len),
    .new_start  (new_start),
    .dout_vld   (dout_vld),
    .dout_rdy   (dout_rdy),
    .dout       (dout),
    .dout_last  (dout_last),
    .fifo_afull (fifo_afull),
    .ovf_flag   (ovf_flag)
  );

  logic [128:0] sb[$];
  int n_checks = 0;
  int n_pass   = 0;
  int m_cnt    = 0;

  // Reference requantization, written with 64-bit integer arithmetic.
  function automatic logic [127:0] model_word(input logic [511:0] d, input logic [511:0] b,
                                              input logic [15:0] m, input logic [4:0] s,
                                              input logic [7:0] zp, input logic r);
    logic [127:0] w;
    longint acc, bias, sum, p, lo, zpl;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      acc  = longint'($signed(d[i*32 +: 32]));
      bias = longint'($signed(b[i*32 +: 32]));
      sum  = acc + bias;
      if (sum > 64'sd2147483647)       sum = 64'sd2147483647;
      else if (sum < -64'sd2147483648) sum = -64'sd2147483648;
      p = sum * longint'(m);
      if (s != 0) p = p + (64'sd1 << (s - 1));
      p = p >>> s;
      zpl = longint'($signed(zp));
      p = p + zpl;
      lo = r ? zpl : -64'sd128;
      if (p > 127)     p = 127;
      else if (p < lo) p = lo;
      w[i*8 +: 8] = p[7:0];
    end
    return w;
  endfunction

  function automatic bit model_last();
    int  eff;
    bit  l;
    eff = (frame_len == 16'd0) ? 65536 : int'(frame_len);
    l = (m_cnt == eff - 1);
    m_cnt = l ? 0 : m_cnt + 1;
    return l;
  endfunction

  // Drives one beat for the current cycle; queues its expected output if it will be stored.
  task automatic set_beat(input logic [511:0] d, input logic [511:0] b, input logic [15:0] m,
                          input logic [4:0] s, input logic [7:0] zp, input logic r, input bit store);
    logic l;
    data_in = d; bias_in = b; q_mult = m; q_shift = s; q_zp = zp; relu_en = r;
    data_in_vld = 1'b1;
    if (store) begin
      l = model_last();
      sb.push_back({l, model_word(d, b, m, s, zp, r)});
    end
  endtask

  task automatic rand_beat(input bit store);
    logic [511:0] d, b;
    int tmp;
    for (int i = 0; i < 16; i++) begin
      tmp = int'($urandom);
      d[i*32 +: 32] = tmp >>> $urandom_range(0, 24);
      tmp = int'($urandom);
      b[i*32 +: 32] = tmp >>> 12;
    end
    set_beat(d, b, 16'($urandom), 5'($urandom_range(8, 24)), 8'($urandom), 1'($urandom), store);
  endtask

  task automatic next_cycle();
    @(posedge clk_100M);
    #1;
  endtask

  task automatic send_one(input logic [511:0] d, input logic [511:0] b, input logic [15:0] m,
                          input logic [4:0] s, input logic [7:0] zp, input logic r);
    set_beat(d, b, m, s, zp, r, 1'b1);
    next_cycle();
    data_in_vld = 1'b0;
  endtask

  task automatic pulse_new_start();
    new_start = 1'b1;
    next_cycle();
    new_start = 1'b0;
    m_cnt = 0;
  endtask

  // Leaves the caller at a negedge where dout_vld is high (or reports a timeout).
  task automatic wait_vld(input string tag);
    int k;
    k = 0;
    @(negedge clk_100M);
    while (!dout_vld && k < 20) begin
      @(negedge clk_100M);
      k++;
    end
    if (!dout_vld) begin
      n_checks++;
      $display("FAIL %s: dout_vld never rose within 20 cycles", tag);
    end
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while ((sb.size() != 0 || dout_vld) && k < 60) begin
      @(negedge clk_100M);
      k++;
    end
    n_checks++;
    if (sb.size() != 0 || dout_vld)
      $display("FAIL %s: drain incomplete, %0d expected beats left, dout_vld=%0b", tag, sb.size(), dout_vld);
    else
      n_pass++;
    next_cycle();
  endtask

  // Scoreboard: every beat that leaves the FIFO is compared in order.
  always @(negedge clk_100M) begin
    if (!rst && dout_vld && dout_rdy) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL scoreboard: unexpected beat got last=%0b dout=%h", dout_last, dout);
      end else begin
        logic [128:0] e;
        e = sb.pop_front();
        if ({dout_last, dout} !== e)
          $display("FAIL scoreboard: got last=%0b dout=%h, want last=%0b dout=%h",
                   dout_last, dout, e[128], e[127:0]);
        else
          n_pass++;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk_100M);
    @(negedge clk_100M);
    n_checks++;
    if ({dout_vld, dout_last, fifo_afull, ovf_flag} !== 4'b0000 || dout !== 128'd0)
      $display("FAIL reset: vld=%0b last=%0b afull=%0b ovf=%0b dout=%h, want all 0",
               dout_vld, dout_last, fifo_afull, ovf_flag, dout);
    else n_pass++;
    next_cycle();
    rst = 1'b0;
    m_cnt = 0;
    next_cycle();
  endtask

  task automatic test_basic();
    logic [511:0] d, b;
    dout_rdy = 1'b1;
    d = '0; b = '0;
    d[31:0] = 32'd1000;
    b[31:0] = 32'd24;
    set_beat(d, b, 16'd3, 5'd4, 8'd0, 1'b0, 1'b1);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk_100M);
      n_checks++;
      if (dout_vld !== (k == 4))
        $display("FAIL latency: cycle N+%0d dout_vld=%0b want %0b", k, dout_vld, (k == 4));
      else n_pass++;
      if (k == 4) begin
        n_checks++;
        if (dout[7:0] !== 8'h7F) $display("FAIL basic_lane0: got %h want 7f", dout[7:0]);
        else n_pass++;
      end
      if (k == 0) begin
        @(posedge clk_100M);
        #1 data_in_vld = 1'b0;
      end
    end
    next_cycle();
    d = '0; b = '0;
    d[63:32] = -32'sd100;
    send_one(d, b, 16'd1, 5'd1, 8'd0, 1'b0);
    wait_vld("basic_lane1");
    n_checks++;
    if (dout[15:8] !== 8'hCE) $display("FAIL basic_lane1: got %h want ce", dout[15:8]);
    else n_pass++;
    next_cycle();
    wait_drain("basic");
  endtask

  task automatic test_sat_relu();
    logic [511:0] d, b;
    d = '0; b = '0;
    d[31:0]  = 32'h7FFF_FFF0; b[31:0]  = 32'h0000_0100;
    d[63:32] = 32'h8000_0010; b[63:32] = 32'hFFFF_FF00;
    send_one(d, b, 16'd1, 5'd0, 8'd0, 1'b0);
    wait_vld("sat");
    n_checks++;
    if (dout[15:0] !== 16'h807F) $display("FAIL sat: got %h want 807f", dout[15:0]);
    else n_pass++;
    next_cycle();
    d = '0; b = '0;
    d[31:0] = -32'sd500;
    send_one(d, b, 16'd1, 5'd0, 8'hFB, 1'b1);
    wait_vld("relu_on");
    n_checks++;
    if (dout[7:0] !== 8'hFB) $display("FAIL relu_on: got %h want fb", dout[7:0]);
    else n_pass++;
    next_cycle();
    send_one(d, b, 16'd1, 5'd0, 8'd0, 1'b0);
    wait_vld("relu_off");
    n_checks++;
    if (dout[7:0] !== 8'h80) $display("FAIL relu_off: got %h want 80", dout[7:0]);
    else n_pass++;
    next_cycle();
    wait_drain("sat_relu");
  endtask

  task automatic test_rounding();
    logic [511:0] d, b;
    logic [31:0]  acc [3];
    logic [4:0]   sh  [3];
    logic [7:0]   want[3];
    acc[0] = 32'd7;         sh[0] = 5'd0;  want[0] = 8'd7;
    acc[1] = 32'h4000_0000; sh[1] = 5'd31; want[1] = 8'd1;
    acc[2] = 32'hC000_0000; sh[2] = 5'd31; want[2] = 8'd0;
    for (int t = 0; t < 3; t++) begin
      d = '0; b = '0;
      d[31:0] = acc[t];
      send_one(d, b, 16'd1, sh[t], 8'd0, 1'b0);
      wait_vld("round");
      n_checks++;
      if (dout[7:0] !== want[t]) $display("FAIL round_%0d: got %h want %h", t, dout[7:0], want[t]);
      else n_pass++;
      next_cycle();
    end
    wait_drain("rounding");
  endtask

  task automatic test_backpressure();
    pulse_new_start();
    dout_rdy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k < 5) rand_beat(1'b1);
      else data_in_vld = 1'b0;
      @(negedge clk_100M);
      if (k == 3) begin
        n_checks++;
        if (dout_vld !== 1'b0) $display("FAIL bp_early: dout_vld=%0b want 0", dout_vld);
        else n_pass++;
      end
      if (k >= 4) begin
        n_checks++;
        if (dout_vld !== 1'b1 || {dout_last, dout} !== sb[0])
          $display("FAIL bp_hold: cycle N+%0d vld=%0b head=%h want %h", k, dout_vld, dout, sb[0][127:0]);
        else n_pass++;
        n_checks++;
        if (fifo_afull !== (k >= 7))
          $display("FAIL bp_afull: cycle N+%0d afull=%0b want %0b", k, fifo_afull, (k >= 7));
        else n_pass++;
      end
      next_cycle();
    end
    dout_rdy = 1'b1;
    wait_drain("backpressure");
  endtask

  task automatic test_overflow();
    pulse_new_start();
    dout_rdy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      rand_beat(k < 8);
      next_cycle();
    end
    data_in_vld = 1'b0;
    repeat (6) next_cycle();
    @(negedge clk_100M);
    n_checks++;
    if ({ovf_flag, fifo_afull, dout_vld} !== 3'b111)
      $display("FAIL ovf_set: ovf=%0b afull=%0b vld=%0b want 1 1 1", ovf_flag, fifo_afull, dout_vld);
    else n_pass++;
    next_cycle();
    dout_rdy = 1'b1;
    wait_drain("overflow");
    @(negedge clk_100M);
    n_checks++;
    if (ovf_flag !== 1'b1) $display("FAIL ovf_sticky: ovf=%0b want 1", ovf_flag);
    else n_pass++;
    next_cycle();
    pulse_new_start();
    @(negedge clk_100M);
    n_checks++;
    if (ovf_flag !== 1'b0) $display("FAIL ovf_clear: ovf=%0b want 0", ovf_flag);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_framing();
    frame_len = 16'd3;
    dout_rdy = 1'b1;
    pulse_new_start();
    for (int k = 0; k < 7; k++) begin
      rand_beat(1'b1);
      next_cycle();
    end
    data_in_vld = 1'b0;
    wait_drain("frame_run");
    pulse_new_start();
    for (int k = 0; k < 2; k++) begin
      rand_beat(1'b1);
      next_cycle();
      data_in_vld = 1'b0;
      repeat (5) next_cycle();
    end
    // This beat's S3 write coincides with new_start, so it restarts as beat 0.
    m_cnt = 0;
    rand_beat(1'b1);
    next_cycle();
    data_in_vld = 1'b0;
    next_cycle();
    next_cycle();
    new_start = 1'b1;
    next_cycle();
    new_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rand_beat(1'b1);
      next_cycle();
    end
    data_in_vld = 1'b0;
    wait_drain("frame_restart");
    frame_len = 16'd0;
  endtask

  task automatic test_reset_flush();
    bit saw;
    pulse_new_start();
    dout_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_beat(1'b1);
      next_cycle();
    end
    data_in_vld = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk_100M);
    n_checks++;
    if (dout_vld !== 1'b1) $display("FAIL flush_pre: dout_vld=%0b want 1", dout_vld);
    else n_pass++;
    next_cycle();
    rand_beat(1'b0);
    next_cycle();
    data_in_vld = 1'b0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    sb.delete();
    m_cnt = 0;
    @(negedge clk_100M);
    n_checks++;
    if ({dout_vld, fifo_afull, dout_last} !== 3'b000 || dout !== 128'd0)
      $display("FAIL flush_rst: vld=%0b afull=%0b last=%0b dout=%h want 0", dout_vld, fifo_afull, dout_last, dout);
    else n_pass++;
    dout_rdy = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_100M);
      if (dout_vld) saw = 1'b1;
    end
    n_checks++;
    if (saw) $display("FAIL flush_stale: got a stale beat after reset, want none");
    else n_pass++;
    next_cycle();
    rand_beat(1'b1);
    next_cycle();
    data_in_vld = 1'b0;
    wait_drain("flush_post");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_sat_relu();
    test_rounding();
    test_backpressure();
    test_overflow();
    test_framing();
    test_reset_flush();
    n_checks++;
    if (sb.size() != 0) $display("FAIL sb_empty: %0d expected beats never produced, want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
